// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Master indices double as the upper ARID_S bit used to route read data back.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      RDATA = 2'd2
   } arb_state_e;

   localparam logic MST_M0 = 1'b0;
   localparam logic MST_M1 = 1'b1;

   localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advanced on update.
// After a grant the pointer favours the other requester; after reset M0 is favoured.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // 0: M0 favoured on a tie, 1: M1 favoured
   logic ptr_q;

   always_comb begin
      grant = 2'b00;
      if (ptr_q == 1'b0) begin
         if (req[0]) begin
            grant = 2'b01;
         end else if (req[1]) begin
            grant = 2'b10;
         end
      end else begin
         if (req[1]) begin
            grant = 2'b10;
         end else if (req[0]) begin
            grant = 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (update) begin
         ptr_q <= grant[0];
      end
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one downstream AXI read channel between an instruction-fetch master (M0) and a
// data-load master (M1); one outstanding transaction, owner keeps R until the RLAST handshake.
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned SIZE_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   // M0 upstream
   input  logic [ID_W-1:0]   ARID_M0,
   input  logic [ADDR_W-1:0] ARADDR_M0,
   input  logic [LEN_W-1:0]  ARLEN_M0,
   input  logic [SIZE_W-1:0] ARSIZE_M0,
   input  logic [1:0]        ARBURST_M0,
   input  logic              ARVALID_M0,
   output logic              ARREADY_M0,
   output logic [ID_W-1:0]   RID_M0,
   output logic [DATA_W-1:0] RDATA_M0,
   output logic [1:0]        RRESP_M0,
   output logic              RLAST_M0,
   output logic              RVALID_M0,
   input  logic              RREADY_M0,
   // M1 upstream
   input  logic [ID_W-1:0]   ARID_M1,
   input  logic [ADDR_W-1:0] ARADDR_M1,
   input  logic [LEN_W-1:0]  ARLEN_M1,
   input  logic [SIZE_W-1:0] ARSIZE_M1,
   input  logic [1:0]        ARBURST_M1,
   input  logic              ARVALID_M1,
   output logic              ARREADY_M1,
   output logic [ID_W-1:0]   RID_M1,
   output logic [DATA_W-1:0] RDATA_M1,
   output logic [1:0]        RRESP_M1,
   output logic              RLAST_M1,
   output logic              RVALID_M1,
   input  logic              RREADY_M1,
   // Downstream
   output logic [ID_W:0]     ARID_S,
   output logic [ADDR_W-1:0] ARADDR_S,
   output logic [LEN_W-1:0]  ARLEN_S,
   output logic [SIZE_W-1:0] ARSIZE_S,
   output logic [1:0]        ARBURST_S,
   output logic              ARVALID_S,
   input  logic              ARREADY_S,
   input  logic [ID_W:0]     RID_S,
   input  logic [DATA_W-1:0] RDATA_S,
   input  logic [1:0]        RRESP_S,
   input  logic              RLAST_S,
   input  logic              RVALID_S,
   output logic              RREADY_S,
   output logic              busy
);

   localparam logic [LEN_W:0] BEAT_MAX = {1'b1, {LEN_W{1'b0}}};

   arb_state_e        state_q;
   logic              ar_en_q;
   logic              owner_q;
   logic              busy_q;
   logic              arvalid_s_q;
   logic [ID_W:0]     arid_s_q;
   logic [ADDR_W-1:0] araddr_s_q;
   logic [LEN_W-1:0]  arlen_s_q;
   logic [SIZE_W-1:0] arsize_s_q;
   logic [1:0]        arburst_s_q;
   logic [LEN_W:0]    beat_cnt_q;
   logic              id_mismatch_q;

   logic [1:0]        arb_req;
   logic [1:0]        grant;
   logic              ar_hs;
   logic              ar_win;
   logic              r_hs;

   logic [ID_W-1:0]   win_id;
   logic [ADDR_W-1:0] win_addr;
   logic [LEN_W-1:0]  win_len;
   logic [SIZE_W-1:0] win_size;
   logic [1:0]        win_burst;

   // AR accept is held off until the first clock after reset release, so ARREADY
   // never reaches a master while reset is asserted.
   assign arb_req = {ARVALID_M1, ARVALID_M0} & {2{ar_en_q && (state_q == IDLE)}};

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (arb_req),
      .update (ar_hs),
      .grant  (grant)
   );

   assign ARREADY_M0 = grant[0];
   assign ARREADY_M1 = grant[1];
   assign ar_hs      = |grant;
   assign ar_win     = grant[1] ? MST_M1 : MST_M0;

   always_comb begin
      win_id    = ARID_M0;
      win_addr  = ARADDR_M0;
      win_len   = ARLEN_M0;
      win_size  = ARSIZE_M0;
      win_burst = ARBURST_M0;
      if (ar_win == MST_M1) begin
         win_id    = ARID_M1;
         win_addr  = ARADDR_M1;
         win_len   = ARLEN_M1;
         win_size  = ARSIZE_M1;
         win_burst = ARBURST_M1;
      end
   end

   // R channel is steered to the owner only while in RDATA; everything else reads 0.
   always_comb begin
      RID_M0    = '0;
      RDATA_M0  = '0;
      RRESP_M0  = '0;
      RLAST_M0  = 1'b0;
      RVALID_M0 = 1'b0;
      RID_M1    = '0;
      RDATA_M1  = '0;
      RRESP_M1  = '0;
      RLAST_M1  = 1'b0;
      RVALID_M1 = 1'b0;
      RREADY_S  = 1'b0;
      if (state_q == RDATA) begin
         if (owner_q == MST_M0) begin
            RID_M0    = RID_S[ID_W-1:0];
            RDATA_M0  = RDATA_S;
            RRESP_M0  = RRESP_S;
            RLAST_M0  = RLAST_S;
            RVALID_M0 = RVALID_S;
            RREADY_S  = RREADY_M0;
         end else begin
            RID_M1    = RID_S[ID_W-1:0];
            RDATA_M1  = RDATA_S;
            RRESP_M1  = RRESP_S;
            RLAST_M1  = RLAST_S;
            RVALID_M1 = RVALID_S;
            RREADY_S  = RREADY_M1;
         end
      end
   end

   assign r_hs = (state_q == RDATA) && RVALID_S && RREADY_S;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ar_en_q       <= 1'b0;
         owner_q       <= MST_M0;
         busy_q        <= 1'b0;
         arvalid_s_q   <= 1'b0;
         arid_s_q      <= '0;
         araddr_s_q    <= '0;
         arlen_s_q     <= '0;
         arsize_s_q    <= '0;
         arburst_s_q   <= '0;
         beat_cnt_q    <= '0;
         id_mismatch_q <= 1'b0;
      end else begin
         ar_en_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (ar_hs) begin
                  arid_s_q    <= {ar_win, win_id};
                  araddr_s_q  <= win_addr;
                  arlen_s_q   <= win_len;
                  arsize_s_q  <= win_size;
                  arburst_s_q <= win_burst;
                  owner_q     <= ar_win;
                  arvalid_s_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ADDR;
               end
            end
            ADDR: begin
               if (ARREADY_S) begin
                  arvalid_s_q <= 1'b0;
                  state_q     <= RDATA;
               end
            end
            RDATA: begin
               // Debug only: a beat tagged for the other master still goes to the owner.
               if (RVALID_S && (RID_S[ID_W] != owner_q)) begin
                  id_mismatch_q <= 1'b1;
               end
               if (r_hs) begin
                  if (RLAST_S) begin
                     beat_cnt_q <= '0;
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end else if (beat_cnt_q != BEAT_MAX) begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ARID_S    = arid_s_q;
   assign ARADDR_S  = araddr_s_q;
   assign ARLEN_S   = arlen_s_q;
   assign ARSIZE_S  = arsize_s_q;
   assign ARBURST_S = arburst_s_q;
   assign ARVALID_S = arvalid_s_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a transaction-level model of both masters
// (pending requests, tie preference) and the downstream slave.
module tb_axi_read_arbiter;
   import axi_arb_pkg::*;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned SIZE_W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [ID_W-1:0]   ARID_M0, ARID_M1, RID_M0, RID_M1;
   logic [ADDR_W-1:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
   logic [LEN_W-1:0]  ARLEN_M0, ARLEN_M1, ARLEN_S;
   logic [SIZE_W-1:0] ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
   logic [1:0]        ARBURST_M0, ARBURST_M1, ARBURST_S;
   logic              ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
   logic [DATA_W-1:0] RDATA_M0, RDATA_M1, RDATA_S;
   logic [1:0]        RRESP_M0, RRESP_M1, RRESP_S;
   logic              RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
   logic [ID_W:0]     ARID_S, RID_S;
   logic              ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, busy;

   axi_read_arbiter #(
      .ID_W   (ID_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .SIZE_W (SIZE_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ARID_M0    (ARID_M0),
      .ARADDR_M0  (ARADDR_M0),
      .ARLEN_M0   (ARLEN_M0),
      .ARSIZE_M0  (ARSIZE_M0),
      .ARBURST_M0 (ARBURST_M0),
      .ARVALID_M0 (ARVALID_M0),
      .ARREADY_M0 (ARREADY_M0),
      .RID_M0     (RID_M0),
      .RDATA_M0   (RDATA_M0),
      .RRESP_M0   (RRESP_M0),
      .RLAST_M0   (RLAST_M0),
      .RVALID_M0  (RVALID_M0),
      .RREADY_M0  (RREADY_M0),
      .ARID_M1    (ARID_M1),
      .ARADDR_M1  (ARADDR_M1),
      .ARLEN_M1   (ARLEN_M1),
      .ARSIZE_M1  (ARSIZE_M1),
      .ARBURST_M1 (ARBURST_M1),
      .ARVALID_M1 (ARVALID_M1),
      .ARREADY_M1 (ARREADY_M1),
      .RID_M1     (RID_M1),
      .RDATA_M1   (RDATA_M1),
      .RRESP_M1   (RRESP_M1),
      .RLAST_M1   (RLAST_M1),
      .RVALID_M1  (RVALID_M1),
      .RREADY_M1  (RREADY_M1),
      .ARID_S     (ARID_S),
      .ARADDR_S   (ARADDR_S),
      .ARLEN_S    (ARLEN_S),
      .ARSIZE_S   (ARSIZE_S),
      .ARBURST_S  (ARBURST_S),
      .ARVALID_S  (ARVALID_S),
      .ARREADY_S  (ARREADY_S),
      .RID_S      (RID_S),
      .RDATA_S    (RDATA_S),
      .RRESP_S    (RRESP_S),
      .RLAST_S    (RLAST_S),
      .RVALID_S   (RVALID_S),
      .RREADY_S   (RREADY_S),
      .busy       (busy)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Master model: a request stays pending (payload frozen) until that master is granted.
   bit                pending [2];
   logic [ID_W-1:0]   p_id    [2];
   logic [ADDR_W-1:0] p_addr  [2];
   logic [LEN_W-1:0]  p_len   [2];
   logic [SIZE_W-1:0] p_size  [2];
   logic [1:0]        p_burst [2];
   int                pref;

   task automatic drive_ar();
      ARVALID_M0 = pending[0];
      ARID_M0    = p_id[0];
      ARADDR_M0  = p_addr[0];
      ARLEN_M0   = p_len[0];
      ARSIZE_M0  = p_size[0];
      ARBURST_M0 = p_burst[0];
      ARVALID_M1 = pending[1];
      ARID_M1    = p_id[1];
      ARADDR_M1  = p_addr[1];
      ARLEN_M1   = p_len[1];
      ARSIZE_M1  = p_size[1];
      ARBURST_M1 = p_burst[1];
   endtask

   task automatic request(input int m, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      if (!pending[m]) begin
         pending[m] = 1'b1;
         p_id[m]    = ID_W'($urandom);
         p_addr[m]  = addr;
         p_len[m]   = len;
         p_size[m]  = SIZE_W'($urandom_range(0, 2));
         p_burst[m] = BURST_INCR;
      end
      drive_ar();
   endtask

   task automatic request_rand(input int m);
      request(m, $urandom & 32'hFFFF_FFFC, LEN_W'($urandom_range(0, 7)));
   endtask

   function automatic int exp_winner();
      if (pending[0] && pending[1]) return pref;
      return pending[1] ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_arready_m0"}, 64'(ARREADY_M0), 64'd0);
      check_eq({tag, "_arready_m1"}, 64'(ARREADY_M1), 64'd0);
      check_eq({tag, "_arvalid_s"}, 64'(ARVALID_S), 64'd0);
      check_eq({tag, "_rready_s"}, 64'(RREADY_S), 64'd0);
      check_eq({tag, "_rvalid_m0"}, 64'(RVALID_M0), 64'd0);
      check_eq({tag, "_rvalid_m1"}, 64'(RVALID_M1), 64'd0);
      check_eq({tag, "_rdata_m"}, 64'(RDATA_M0 | RDATA_M1), 64'd0);
      check_eq({tag, "_arid_s"}, 64'(ARID_S), 64'd0);
      check_eq({tag, "_araddr_s"}, 64'(ARADDR_S), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // One full transaction for whichever master the model expects to win.
   task automatic run_txn(input int ar_stall, input int r_stall, input int nbeats,
                          input bit bad_id, input int abort_beat,
                          input bit use_d0, input logic [DATA_W-1:0] d0);
      int                w;
      int                beats;
      int                stall;
      logic [ID_W:0]     e_arid;
      logic [ADDR_W-1:0] e_addr;
      logic [LEN_W-1:0]  e_len;
      logic [SIZE_W-1:0] e_size;
      logic [1:0]        e_burst;
      logic [DATA_W-1:0] d;
      logic [ID_W-1:0]   rid;
      logic [1:0]        resp;
      logic              last;
      logic              rdy;
      w = exp_winner();
      #1;
      check_eq("arready_m0", 64'(ARREADY_M0), 64'(w == 0));
      check_eq("arready_m1", 64'(ARREADY_M1), 64'(w == 1));
      check_eq("busy_idle", 64'(busy), 64'd0);
      e_arid  = {w[0], p_id[w]};
      e_addr  = p_addr[w];
      e_len   = p_len[w];
      e_size  = p_size[w];
      e_burst = p_burst[w];
      tick();
      pending[w] = 1'b0;
      drive_ar();
      pref = 1 - w;
      // Stray read data before the address phase completes must be ignored.
      RVALID_S  = 1'b1;
      RDATA_S   = $urandom;
      RLAST_S   = 1'b1;
      RID_S     = {w[0], ID_W'($urandom)};
      RREADY_M0 = 1'b1;
      RREADY_M1 = 1'b1;
      for (int i = 0; i <= ar_stall; i++) begin
         ARREADY_S = (i == ar_stall);
         #1;
         check_eq("arvalid_s", 64'(ARVALID_S), 64'd1);
         check_eq("arid_s", 64'(ARID_S), 64'(e_arid));
         check_eq("araddr_s", 64'(ARADDR_S), 64'(e_addr));
         check_eq("arlen_s", 64'(ARLEN_S), 64'(e_len));
         check_eq("arsize_s", 64'(ARSIZE_S), 64'(e_size));
         check_eq("arburst_s", 64'(ARBURST_S), 64'(e_burst));
         check_eq("busy_addr", 64'(busy), 64'd1);
         check_eq("rready_s_addr", 64'(RREADY_S), 64'd0);
         check_eq("rvalid_m_addr", 64'(RVALID_M0 | RVALID_M1), 64'd0);
         check_eq("arready_addr", 64'(ARREADY_M0 | ARREADY_M1), 64'd0);
         tick();
      end
      ARREADY_S = 1'b0;
      RVALID_S  = 1'b0;
      RLAST_S   = 1'b0;
      #1;
      check_eq("arvalid_s_drop", 64'(ARVALID_S), 64'd0);
      beats = (nbeats > 0) ? nbeats : int'(e_len) + 1;
      for (int b = 0; b < beats; b++) begin
         d    = (use_d0 && b == 0) ? d0 : $urandom;
         rid  = ID_W'($urandom);
         resp = 2'($urandom);
         last = (b == beats - 1);
         RVALID_S = 1'b1;
         RDATA_S  = d;
         RRESP_S  = resp;
         RLAST_S  = last;
         RID_S    = {bad_id ? ~w[0] : w[0], rid};
         if (r_stall >= 0) stall = r_stall;
         else stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         for (int s = 0; s <= stall; s++) begin
            rdy = (s == stall);
            if (w == 0) begin
               RREADY_M0 = rdy;
               RREADY_M1 = 1'($urandom);
            end else begin
               RREADY_M1 = rdy;
               RREADY_M0 = 1'($urandom);
            end
            #1;
            check_eq("rvalid_owner", 64'((w == 0) ? RVALID_M0 : RVALID_M1), 64'd1);
            check_eq("rvalid_other", 64'((w == 0) ? RVALID_M1 : RVALID_M0), 64'd0);
            check_eq("rdata_owner", 64'((w == 0) ? RDATA_M0 : RDATA_M1), 64'(d));
            check_eq("rid_owner", 64'((w == 0) ? RID_M0 : RID_M1), 64'(rid));
            check_eq("rresp_owner", 64'((w == 0) ? RRESP_M0 : RRESP_M1), 64'(resp));
            check_eq("rlast_owner", 64'((w == 0) ? RLAST_M0 : RLAST_M1), 64'(last));
            check_eq("rready_s", 64'(RREADY_S), 64'(rdy));
            check_eq("arready_rdata", 64'(ARREADY_M0 | ARREADY_M1), 64'd0);
            if (b == abort_beat) begin
               #2;
               rst_n = 1'b0;
               #1;
               check_all_zero("rst_mid");
               RVALID_S  = 1'b0;
               RLAST_S   = 1'b0;
               RREADY_M0 = 1'b0;
               RREADY_M1 = 1'b0;
               return;
            end
            tick();
         end
      end
      RVALID_S  = 1'b0;
      RLAST_S   = 1'b0;
      RREADY_M0 = 1'b0;
      RREADY_M1 = 1'b0;
      #1;
      check_eq("busy_end", 64'(busy), 64'd0);
      check_eq("rvalid_end", 64'(RVALID_M0 | RVALID_M1), 64'd0);
      check_eq("arvalid_s_end", 64'(ARVALID_S), 64'd0);
   endtask

   initial begin
      pending[0] = 1'b0;
      pending[1] = 1'b0;
      for (int m = 0; m < 2; m++) begin
         p_id[m] = '0; p_addr[m] = '0; p_len[m] = '0; p_size[m] = '0; p_burst[m] = '0;
      end
      pref = 0;
      drive_ar();
      ARREADY_S = 1'b0; RVALID_S = 1'b0; RLAST_S = 1'b0; RDATA_S = '0; RRESP_S = '0; RID_S = '0;
      RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;

      // Reset: masters requesting must still see nothing
      repeat (3) @(posedge clk);
      ARVALID_M0 = 1'b1;
      ARVALID_M1 = 1'b1;
      #1;
      check_all_zero("reset");
      drive_ar();
      rst_n = 1'b1;
      tick();
      tick();

      // Single beat from M0
      request(0, 32'h0000_0010, 4'd0);
      run_txn(0, 0, -1, 1'b0, -1, 1'b1, 32'hDEADBEEF);

      // Simultaneous requests, twice
      request_rand(0); request_rand(1);
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);
      request_rand(0); request_rand(1);
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);
      run_txn(0, -1, -1, 1'b0, -1, 1'b0, '0);

      // 4-beat burst with the other master waiting
      request(pref, 32'h0000_1000, 4'd3);
      request(1 - pref, 32'h0000_2000, 4'd1);
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);

      // Downstream AR stall, owner R stall, RLAST beyond ARLEN and counter range, wrong RID tag
      request_rand(0);
      run_txn(5, 0, -1, 1'b0, -1, 1'b0, '0);
      request_rand(1);
      run_txn(0, 3, -1, 1'b0, -1, 1'b0, '0);
      request(1, 32'h0000_3000, 4'd1);
      run_txn(1, 0, 20, 1'b0, -1, 1'b0, '0);
      request_rand(0);
      run_txn(0, -1, -1, 1'b1, -1, 1'b0, '0);

      // Reset mid-burst; afterwards M0 must win a tie again
      request(0, 32'h0000_4000, 4'd7);
      request(1, 32'h0000_5000, 4'd7);
      run_txn(0, 0, -1, 1'b0, 2, 1'b0, '0);
      pending[0] = 1'b0;
      pending[1] = 1'b0;
      pref = 0;
      request_rand(0);
      request_rand(1);
      tick();
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      tick();
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);
      run_txn(0, 0, -1, 1'b0, -1, 1'b0, '0);

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         if (!pending[0] && $urandom_range(0, 1) == 1) request_rand(0);
         if (!pending[1] && $urandom_range(0, 1) == 1) request_rand(1);
         if (!pending[0] && !pending[1]) request_rand(int'($urandom_range(0, 1)));
         run_txn(int'($urandom_range(0, 3)), -1, -1, ($urandom_range(0, 7) == 0), -1, 1'b0, '0);
      end
      for (int k = 0; k < 2; k++) begin
         if (pending[0] || pending[1]) run_txn(0, -1, -1, 1'b0, -1, 1'b0, '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
